// File: rtl/cont_chain_seq_pkg.sv
// Shared types and defaults for the display-chain continuation sequencer.
// No logic and no latency; backpressure is not applicable.
package cont_chain_seq_pkg;

    localparam int CONT_STATE_BITS   = 2;
    localparam int DEFAULT_N_STAGES  = 3;
    localparam int DEFAULT_PASS_BITS = 8;
    localparam int DEFAULT_TO_BITS   = 24;

    typedef enum logic [CONT_STATE_BITS-1:0] {
        CONT_IDLE  = 2'd0,
        CONT_WAIT  = 2'd1,
        CONT_FAULT = 2'd2
    } cont_state_e;

    // Index width that stays legal for the smallest chain.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cont_chain_seq_if.sv
// Control/status bundle between game-level control and the stage sequencer.
// Pure wiring, zero latency; stages hold go until done, no other backpressure.
interface cont_chain_seq_if
    import cont_chain_seq_pkg::*;
#(
    parameter int N_STAGES  = DEFAULT_N_STAGES,
    parameter int PASS_BITS = DEFAULT_PASS_BITS
);
    localparam int IDX_W = idx_bits(N_STAGES);

    logic                 working;
    logic                 loop_en;
    logic                 err_clr;
    logic [N_STAGES-1:0]  stage_done;
    logic [N_STAGES-1:0]  stage_go;
    logic [IDX_W-1:0]     active_stage;
    logic                 busy;
    logic                 frame_done;
    logic [PASS_BITS-1:0] pass_cnt;
    logic                 timeout_err;
    logic                 protocol_err;

    modport master (
        output working, loop_en, err_clr, stage_done,
        input  stage_go, active_stage, busy, frame_done, pass_cnt,
               timeout_err, protocol_err
    );

    modport slave (
        input  working, loop_en, err_clr, stage_done,
        output stage_go, active_stage, busy, frame_done, pass_cnt,
               timeout_err, protocol_err
    );

endinterface

// File: rtl/cont_chain_seq_watchdog.sv
// Per-stage cycle watchdog; expired is combinational from the count, asserted on the
// TIMEOUT_CYCLES-th cycle of run since the last clr; never expires when TIMEOUT_CYCLES=0.
module cont_watchdog #(
    parameter int TO_BITS        = 24,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic Clck,
    input  logic Reset,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam bit                 ENABLE = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_BITS-1:0] LIMIT  = ENABLE ? TO_BITS'(TIMEOUT_CYCLES - 1) : '0;

    logic [TO_BITS-1:0] cnt_q;

    // The edge that would bring the count to TIMEOUT_CYCLES is the faulting edge.
    assign expired = ENABLE && run && (cnt_q == LIMIT);

    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (ENABLE && run && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/cont_chain_seq.sv
// Chains N stages with one-hot level go, advancing on the active stage's done; go moves
// on the same edge as done (1-cycle start latency), stages stall the chain by withholding done.
module cont_chain_seq
    import cont_chain_seq_pkg::*;
#(
    parameter int N_STAGES       = DEFAULT_N_STAGES,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TO_BITS        = DEFAULT_TO_BITS,
    parameter int PASS_BITS      = DEFAULT_PASS_BITS
) (
    input  logic              Clck,
    input  logic              Reset,
    cont_chain_seq_if.slave   bus
);

    localparam int                  IDX_W    = idx_bits(N_STAGES);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_STAGES - 1);
    localparam logic [N_STAGES-1:0] GO_FIRST = N_STAGES'(1);

    cont_state_e          state_q, state_d;
    logic [N_STAGES-1:0]  go_q, go_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 frame_done_q, frame_done_d;
    logic [PASS_BITS-1:0] pass_q, pass_d;
    logic                 terr_q, terr_d;
    logic                 perr_q, perr_d;
    logic                 working_q;
    logic                 armed_q;

    logic start;
    logic done_active;
    logic done_other;
    logic wd_run;
    logic wd_clr;
    logic wd_expired;

    // armed_q keeps a working level held across reset from counting as a fresh edge.
    assign start       = bus.working && !working_q && armed_q;
    assign done_active = |(bus.stage_done & go_q);
    assign done_other  = |(bus.stage_done & ~go_q);
    assign wd_run      = (state_q == CONT_WAIT);
    assign wd_clr      = !wd_run || done_active;

    cont_watchdog #(
        .TO_BITS        (TO_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .Clck    (Clck),
        .Reset   (Reset),
        .clr     (wd_clr),
        .run     (wd_run),
        .expired (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        go_d         = go_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        pass_d       = pass_q;
        terr_d       = terr_q;
        perr_d       = perr_q;

        // Clear first so an error raised on this same edge overrides it.
        if (bus.err_clr) begin
            terr_d = 1'b0;
            perr_d = 1'b0;
        end

        unique case (state_q)
            CONT_IDLE: begin
                if (start) begin
                    state_d = CONT_WAIT;
                    go_d    = GO_FIRST;
                    idx_d   = '0;
                end
            end

            CONT_WAIT: begin
                if (done_other) begin
                    perr_d = 1'b1;
                end
                if (done_active) begin
                    if (idx_q != LAST_IDX) begin
                        go_d  = go_q << 1;
                        idx_d = idx_q + 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                        pass_d       = pass_q + 1'b1;
                        idx_d        = '0;
                        if (bus.loop_en) begin
                            go_d = GO_FIRST;
                        end else begin
                            go_d    = '0;
                            state_d = CONT_IDLE;
                        end
                    end
                end else if (wd_expired) begin
                    go_d    = '0;
                    terr_d  = 1'b1;
                    state_d = CONT_FAULT;
                end
            end

            CONT_FAULT: begin
                go_d = '0;
                if (bus.err_clr) begin
                    state_d = CONT_IDLE;
                    idx_d   = '0;
                end
            end

            default: begin
                state_d = CONT_IDLE;
                go_d    = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            state_q      <= CONT_IDLE;
            go_q         <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            pass_q       <= '0;
            terr_q       <= 1'b0;
            perr_q       <= 1'b0;
            working_q    <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            go_q         <= go_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            pass_q       <= pass_d;
            terr_q       <= terr_d;
            perr_q       <= perr_d;
            working_q    <= bus.working;
            armed_q      <= armed_q | ~bus.working;
        end
    end

    assign bus.stage_go     = go_q;
    assign bus.active_stage = idx_q;
    assign bus.busy         = (state_q == CONT_WAIT);
    assign bus.frame_done   = frame_done_q;
    assign bus.pass_cnt     = pass_q;
    assign bus.timeout_err  = terr_q;
    assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_cont_chain_seq.sv
// Bench for cont_chain_seq: watchdog instance (16 cycles) plus a watchdog-disabled instance.
// Pass counts are scoreboarded at every frame_done pulse.
module tb_cont_chain_seq;

    localparam int N  = 3;
    localparam int PB = 8;
    localparam int TO = 16;

    logic Clck = 1'b0;
    logic Reset;

    always #5 Clck = ~Clck;

    cont_chain_seq_if #(.N_STAGES(N), .PASS_BITS(PB)) ifa ();
    cont_chain_seq_if #(.N_STAGES(N), .PASS_BITS(PB)) ifb ();

    cont_chain_seq #(
        .N_STAGES(N), .TIMEOUT_CYCLES(TO), .TO_BITS(24), .PASS_BITS(PB)
    ) dut_a (
        .Clck  (Clck),
        .Reset (Reset),
        .bus   (ifa.slave)
    );

    cont_chain_seq #(
        .N_STAGES(N), .TIMEOUT_CYCLES(0), .TO_BITS(24), .PASS_BITS(PB)
    ) dut_b (
        .Clck  (Clck),
        .Reset (Reset),
        .bus   (ifb.slave)
    );

    int             n_chk  = 0;
    int             n_fail = 0;
    logic [PB-1:0]  exp_pass;
    logic [PB-1:0]  sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clck);
            #1;
        end
    endtask

    task automatic start_a();
        ifa.working = 1'b0;
        tick();
        ifa.working = 1'b1;
        tick();
        ifa.working = 1'b0;
        chk("start_go", ifa.stage_go, 1);
    endtask

    // Hold stage k for dly cycles, then complete it and check the handover.
    task automatic done_a(input int k, input int dly);
        logic [N-1:0] nxt;
        tick(dly);
        chk("go_hold", ifa.stage_go, 32'(1 << k));
        ifa.stage_done = N'(1 << k);
        if (k == N - 1) begin
            exp_pass = exp_pass + 1'b1;
            sb.push_back(exp_pass);
            nxt = ifa.loop_en ? N'(1) : '0;
        end else begin
            nxt = N'(1 << (k + 1));
        end
        tick();
        ifa.stage_done = '0;
        chk("go_next", ifa.stage_go, nxt);
        chk("active_next", ifa.active_stage, (k == N - 1) ? 0 : k + 1);
    endtask

    always @(negedge Clck) begin
        if (ifa.frame_done === 1'b1) begin
            if (sb.size() == 0)
                chk("frame_unexpected", ifa.frame_done, 0);
            else
                chk("pass_cnt_sb", ifa.pass_cnt, sb.pop_front());
        end
    end

    initial begin
        Reset          = 1'b1;
        ifa.working    = 1'b0;
        ifa.loop_en    = 1'b0;
        ifa.err_clr    = 1'b0;
        ifa.stage_done = '0;
        ifb.working    = 1'b0;
        ifb.loop_en    = 1'b0;
        ifb.err_clr    = 1'b0;
        ifb.stage_done = '0;
        exp_pass       = '0;
        tick(2);

        chk("rst_go",    ifa.stage_go, 0);
        chk("rst_act",   ifa.active_stage, 0);
        chk("rst_busy",  ifa.busy, 0);
        chk("rst_frame", ifa.frame_done, 0);
        chk("rst_pass",  ifa.pass_cnt, 0);
        chk("rst_terr",  ifa.timeout_err, 0);
        chk("rst_perr",  ifa.protocol_err, 0);
        Reset = 1'b0;
        tick(2);

        // One pass, loop_en=0; a start edge during WAIT must not queue.
        ifa.working = 1'b1;
        tick();
        chk("p1_go", ifa.stage_go, 1);
        chk("p1_busy", ifa.busy, 1);
        ifa.working = 1'b0;
        done_a(0, 3);
        done_a(1, 2);
        ifa.working = 1'b1;
        tick();
        done_a(2, 1);
        chk("p1_frame", ifa.frame_done, 1);
        chk("p1_busy_end", ifa.busy, 0);
        chk("p1_pass", ifa.pass_cnt, 1);
        tick();
        chk("p1_frame_pulse", ifa.frame_done, 0);
        chk("p1_no_queue", ifa.stage_go, 0);
        ifa.working = 1'b0;

        // Loop mode from a clean counter: 300 passes, then drop loop_en in stage 1.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_pass = '0;
        ifa.loop_en = 1'b1;
        start_a();
        for (int p = 0; p < 300; p++) begin
            for (int k = 0; k < N; k++) done_a(k, 1);
        end
        chk("loop_pass300", ifa.pass_cnt, 44);
        chk("loop_busy", ifa.busy, 1);
        done_a(0, 1);
        tick();
        ifa.loop_en = 1'b0;
        done_a(1, 1);
        done_a(2, 1);
        chk("loop_stop_busy", ifa.busy, 0);
        chk("loop_stop_pass", ifa.pass_cnt, 45);
        tick(3);
        chk("loop_stop_idle", ifa.stage_go, 0);

        // Watchdog: stage 1 never completes.
        start_a();
        done_a(0, 0);
        tick(TO - 1);
        chk("wd_before", ifa.stage_go, 2);
        chk("wd_before_err", ifa.timeout_err, 0);
        tick();
        chk("wd_go", ifa.stage_go, 0);
        chk("wd_err", ifa.timeout_err, 1);
        chk("wd_act", ifa.active_stage, 1);
        chk("wd_busy", ifa.busy, 0);
        chk("wd_pass_hold", ifa.pass_cnt, 45);
        ifa.working = 1'b1;
        tick();
        ifa.working = 1'b0;
        tick();
        chk("fault_ignore_start", ifa.stage_go, 0);
        chk("fault_sticky", ifa.timeout_err, 1);
        ifa.err_clr = 1'b1;
        tick();
        ifa.err_clr = 1'b0;
        chk("clr_terr", ifa.timeout_err, 0);
        chk("clr_act", ifa.active_stage, 0);
        chk("clr_go", ifa.stage_go, 0);
        tick();
        chk("clr_no_queue", ifa.stage_go, 0);
        start_a();
        done_a(0, 2);
        done_a(1, 2);
        done_a(2, 2);

        // Protocol error, then done on the exact timeout edge.
        start_a();
        ifa.stage_done = 3'b100;
        tick();
        ifa.stage_done = '0;
        chk("perr_set", ifa.protocol_err, 1);
        chk("perr_go", ifa.stage_go, 1);
        tick(TO - 2);
        done_a(0, 0);
        chk("collide_terr", ifa.timeout_err, 0);
        chk("collide_busy", ifa.busy, 1);
        ifa.err_clr = 1'b1;
        tick();
        chk("perr_clr", ifa.protocol_err, 0);
        ifa.stage_done = 3'b001;
        tick();
        ifa.stage_done = '0;
        ifa.err_clr = 1'b0;
        chk("perr_wins_clr", ifa.protocol_err, 1);
        chk("perr_go1", ifa.stage_go, 2);
        done_a(1, 1);
        done_a(2, 1);

        // Asynchronous reset mid-cycle with working held high.
        ifa.working = 1'b0;
        tick();
        ifa.working = 1'b1;
        tick();
        done_a(0, 1);
        #3;
        Reset = 1'b1;
        #1;
        chk("arst_go", ifa.stage_go, 0);
        chk("arst_pass", ifa.pass_cnt, 0);
        chk("arst_act", ifa.active_stage, 0);
        exp_pass = '0;
        tick();
        Reset = 1'b0;
        tick(3);
        chk("arst_held_go", ifa.stage_go, 0);
        chk("arst_held_busy", ifa.busy, 0);
        ifa.working = 1'b0;
        tick();
        ifa.working = 1'b1;
        tick();
        chk("arst_restart", ifa.stage_go, 1);
        ifa.working = 1'b0;
        done_a(0, 1);
        done_a(1, 1);
        done_a(2, 1);

        // Watchdog disabled: stage 0 held without done.
        ifb.working = 1'b1;
        tick();
        chk("nowd_go", ifb.stage_go, 1);
        tick(3000);
        chk("nowd_go_held", ifb.stage_go, 1);
        chk("nowd_terr", ifb.timeout_err, 0);
        chk("nowd_busy", ifb.busy, 1);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
